// File: rtl/pipeline_ctrl_pkg.sv
// Shared state encoding and defaults for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

  localparam int unsigned DRAIN_CYCLES_DEF = 4;
  localparam int unsigned NB_STALL_CNT_DEF = 16;
  localparam int unsigned DRAIN_CNT_W      = 3;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_PAUSE  = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Request/enable bundle between ID-stage hazard logic and the pipeline controller.
interface pipeline_ctrl_if #(
  parameter int unsigned NB_STALL_CNT = 16
);

  logic                    i_hazard;
  logic                    i_branch_taken;
  logic                    i_halt;
  logic                    i_debug_mode;
  logic                    i_step;
  logic                    o_pc_we;
  logic                    o_ifid_we;
  logic                    o_ifid_flush;
  logic                    o_idex_bubble;
  logic                    o_pipe_en;
  logic                    o_halted;
  logic [NB_STALL_CNT-1:0] o_stall_count;

  modport master (
    output i_hazard, i_branch_taken, i_halt, i_debug_mode, i_step,
    input  o_pc_we, o_ifid_we, o_ifid_flush, o_idex_bubble, o_pipe_en,
           o_halted, o_stall_count
  );

  modport slave (
    input  i_hazard, i_branch_taken, i_halt, i_debug_mode, i_step,
    output o_pc_we, o_ifid_we, o_ifid_flush, o_idex_bubble, o_pipe_en,
           o_halted, o_stall_count
  );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clock,
  input  logic             i_clear_n,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_en && (count_q != CNT_MAX)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_clear_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Turns hazard/branch/halt/debug requests into per-stage pipeline write enables.
// Optional stall-cycle counter is built only when STALL_CNT_EN is defined.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int unsigned NB_STALL_CNT = NB_STALL_CNT_DEF
) (
  input  logic            i_clock,
  input  logic            i_reset,
  pipeline_ctrl_if.slave  bus
);

  localparam logic [DRAIN_CNT_W-1:0] DRAIN_INIT = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

  state_t                 state_q;
  state_t                 state_d;
  logic [DRAIN_CNT_W-1:0] drain_cnt_q;
  logic [DRAIN_CNT_W-1:0] drain_cnt_d;
  logic                   active;

  logic pc_we;
  logic ifid_we;
  logic ifid_flush;
  logic idex_bubble;
  logic pipe_en;
  logic halted;

  assign active = (state_q == ST_RUN) || (state_q == ST_STEP);

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // A halt shadowed by a hazard is not accepted; ID re-presents it next cycle.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      ST_RUN, ST_STEP: begin
        if (bus.i_halt && !bus.i_hazard) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DRAIN_INIT;
        end else if (state_q == ST_STEP) begin
          state_d = ST_PAUSE;
        end else if (bus.i_debug_mode) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (bus.i_step) begin
          state_d = ST_STEP;
        end else if (!bus.i_debug_mode) begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d = ST_HALTED;
        end else begin
          drain_cnt_d = drain_cnt_q - DRAIN_CNT_W'(1);
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // Same-cycle decode: a load-use hazard must freeze PC and IF/ID immediately.
  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_en     = 1'b0;
    halted      = 1'b0;
    if (i_reset) begin
      unique case (state_q)
        ST_RUN, ST_STEP: begin
          pipe_en = 1'b1;
          if (bus.i_hazard) begin
            idex_bubble = 1'b1;
          end else if (bus.i_halt) begin
            ifid_flush = 1'b1;
          end else if (bus.i_branch_taken) begin
            pc_we      = 1'b1;
            ifid_we    = 1'b1;
            ifid_flush = 1'b1;
          end else begin
            pc_we   = 1'b1;
            ifid_we = 1'b1;
          end
        end
        ST_DRAIN: begin
          pipe_en     = 1'b1;
          idex_bubble = 1'b1;
        end
        ST_HALTED: halted = 1'b1;
        default:   halted = 1'b0;
      endcase
    end
  end

  assign bus.o_pc_we       = pc_we;
  assign bus.o_ifid_we     = ifid_we;
  assign bus.o_ifid_flush  = ifid_flush;
  assign bus.o_idex_bubble = idex_bubble;
  assign bus.o_pipe_en     = pipe_en;
  assign bus.o_halted      = halted;

`ifdef STALL_CNT_EN
  logic stall_inc;

  // Only hazard bubbles count; drain bubbles are excluded.
  assign stall_inc = i_reset && active && bus.i_hazard;

  sat_counter #(
    .WIDTH (NB_STALL_CNT)
  ) u_stall_cnt (
    .i_clock   (i_clock),
    .i_clear_n (i_reset),
    .i_en      (stall_inc),
    .o_count   (bus.o_stall_count)
  );
`else
  logic unused_active;

  assign unused_active     = active;
  assign bus.o_stall_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: two instances (16-bit and 2-bit stall counters).
module tb_pipeline_ctrl;

  typedef struct packed {
    logic        pc_we;
    logic        ifid_we;
    logic        flush;
    logic        bubble;
    logic        pipe_en;
    logic        halted;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  localparam int DRAIN = 4;

  logic clk;
  logic rst;
  logic hz, br, ht, dbg, stp;

  pipeline_ctrl_if #(.NB_STALL_CNT(16)) bus16 ();
  pipeline_ctrl_if #(.NB_STALL_CNT(2))  bus2 ();

  assign bus16.i_hazard       = hz;
  assign bus16.i_branch_taken = br;
  assign bus16.i_halt         = ht;
  assign bus16.i_debug_mode   = dbg;
  assign bus16.i_step         = stp;
  assign bus2.i_hazard        = hz;
  assign bus2.i_branch_taken  = br;
  assign bus2.i_halt          = ht;
  assign bus2.i_debug_mode    = dbg;
  assign bus2.i_step          = stp;

  pipeline_ctrl #(.DRAIN_CYCLES(DRAIN), .NB_STALL_CNT(16)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus16)
  );

  pipeline_ctrl #(.DRAIN_CYCLES(DRAIN), .NB_STALL_CNT(2)) dut_sat (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc    = 0;

  // Reference model: plain flags, not a state encoding.
  bit m_paused, m_stepping, m_halted;
  int m_drain_left;   // -1 when not draining
  int m_cnt, m_cnt2;

  task automatic model_reset();
    m_paused = 0; m_stepping = 0; m_halted = 0; m_drain_left = -1;
    m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic cycle(input bit r, input bit h, input bit b, input bit hl,
                       input bit d, input bit s);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; hz = h; br = b; ht = hl; dbg = d; stp = s;
    e = '0;
`ifdef STALL_CNT_EN
    e.cnt  = 16'(m_cnt);
    e.cnt2 = 2'(m_cnt2);
`endif
    if (!r) begin
      exp_q.push_back(e);
      model_reset();
      return;
    end
    if (m_halted) begin
      e.halted = 1'b1;
    end else if (m_drain_left >= 0) begin
      e.pipe_en = 1'b1;
      e.bubble  = 1'b1;
      if (m_drain_left == 0) m_halted = 1;
      m_drain_left = m_drain_left - 1;
    end else if (m_paused && !m_stepping) begin
      if (s) m_stepping = 1;
      else if (!d) m_paused = 0;
    end else begin
      e.pipe_en = 1'b1;
      if (h) begin
        e.bubble = 1'b1;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (m_cnt2 < 3) m_cnt2 = m_cnt2 + 1;
      end else if (hl) begin
        e.flush = 1'b1;
      end else if (b) begin
        e.pc_we = 1'b1; e.ifid_we = 1'b1; e.flush = 1'b1;
      end else begin
        e.pc_we = 1'b1; e.ifid_we = 1'b1;
      end
      if (hl && !h) begin
        m_drain_left = DRAIN - 1;
        m_paused = 0; m_stepping = 0;
      end else if (m_stepping) begin
        m_stepping = 0;
      end else if (d) begin
        m_paused = 1;
      end
    end
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus16.o_pc_we, bus16.o_ifid_we, bus16.o_ifid_flush, bus16.o_idex_bubble,
           bus16.o_pipe_en, bus16.o_halted, bus16.o_stall_count, bus2.o_stall_count};
      checks = checks + 1;
      cyc    = cyc + 1;
      if (a !== e) begin
        $display("FAIL outputs cycle %0d: got pc=%b ifid=%b flush=%b bubble=%b pipe=%b halted=%b cnt=%0d cnt2=%0d, want pc=%b ifid=%b flush=%b bubble=%b pipe=%b halted=%b cnt=%0d cnt2=%0d",
                 cyc, a.pc_we, a.ifid_we, a.flush, a.bubble, a.pipe_en, a.halted, a.cnt, a.cnt2,
                 e.pc_we, e.ifid_we, e.flush, e.bubble, e.pipe_en, e.halted, e.cnt, e.cnt2);
      end else begin
        passed = passed + 1;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit d_lvl;
    rst = 1'b0; hz = 1'b1; br = 1'b1; ht = 1'b1; dbg = 1'b1; stp = 1'b1;
    model_reset();

    // Reset held with every input high, then release into RUN.
    repeat (3) cycle(0, 1, 1, 1, 1, 1);
    repeat (2) cycle(1, 0, 0, 0, 0, 0);
    // Load-use, hazard+branch, branch re-presented.
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
    // Debug pause with three spaced steps, then resume.
    cycle(1, 0, 0, 0, 1, 0);
    repeat (2) cycle(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 0, 1, 1);
      repeat (4) cycle(1, 0, 0, 0, 1, 0);
    end
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    // Hazard held long enough to saturate the narrow counter.
    repeat (6) cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    // Halt, drain with noisy inputs, then halted.
    cycle(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) cycle(1, 1, 1, 0, 1, 1'(i % 2));

    // Randomized sessions, each starting from reset.
    for (int sess = 0; sess < 25; sess++) begin
      cycle(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      d_lvl = 1'b0;
      for (int k = 0; k < 40; k++) begin
        if ($urandom_range(7) == 0) d_lvl = ~d_lvl;
        cycle(1, ($urandom_range(4) == 0), ($urandom_range(3) == 0),
              ($urandom_range(29) == 0), d_lvl, ($urandom_range(3) == 0));
      end
    end

    begin
      int waited;
      waited = 0;
      while (exp_q.size() > 0 && waited < 20) begin
        @(posedge clk);
        waited = waited + 1;
      end
      if (exp_q.size() > 0) begin
        checks = checks + 1;
        $display("FAIL drain_queue: %0d expected entries left, required 0", exp_q.size());
      end
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Consumer of the load-use hazard flag. Turns hazard, branch-flush, halt and debug-step requests into per-stage write enables for the 5-stage MIPS pipeline: PC, IF/ID, ID/EX bubble, and the global pipe enable. Owns the halt drain sequence, debug pause/single-step, and a stall-cycle performance counter. Sits between the ID-stage hazard/branch logic and all pipeline registers and the PC.

Parameters:
DRAIN_CYCLES, 4, cycles after a halt is accepted for in-flight instructions to retire (EX, MEM, WB plus 1); legal range 1..7
NB_STALL_CNT, 16, width of the stall-cycle counter

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous reset, active-low
i_hazard  in  1  load-use hazard from ID (combinational, same cycle)
i_branch_taken  in  1  branch/jump resolved taken in ID
i_halt  in  1  halt opcode decoded in ID
i_debug_mode  in  1  level; 1 = pipeline paused except on steps
i_step  in  1  single-cycle pulse; advance one cycle while paused
o_pc_we  out  1  PC write enable
o_ifid_we  out  1  IF/ID register write enable
o_ifid_flush  out  1  load NOP into IF/ID
o_idex_bubble  out  1  load NOP (zeroed control) into ID/EX
o_pipe_en  out  1  enable for ID/EX, EX/MEM, MEM/WB registers
o_halted  out  1  pipeline fully drained and stopped
o_stall_count  out  NB_STALL_CNT  saturating count of hazard stall cycles

Behaviour:
- States: RUN, PAUSE, STEP, DRAIN, HALTED. State and drain counter are registered; outputs are a combinational decode of state and inputs (hazard must stall in the same cycle).
- Reset (i_reset=0 at posedge): state=RUN, drain counter=0, stall count=0. While i_reset is low the outputs are forced: pc_we=0, ifid_we=0, flush=0, bubble=0, pipe_en=0, halted=0.
- RUN/STEP active cycle, priority hazard > halt > branch:
  - hazard: pc_we=0, ifid_we=0, bubble=1, pipe_en=1, flush=0. Branch and halt are ignored this cycle; they are re-presented next cycle with correct operands.
  - halt (no hazard): pc_we=0, ifid_we=0, flush=1, pipe_en=1. Next state is DRAIN with counter=DRAIN_CYCLES-1.
  - branch_taken (no hazard): pc_we=1, ifid_we=1, flush=1, pipe_en=1.
  - none of the above: pc_we=ifid_we=pipe_en=1, flush=bubble=0.
- RUN with i_debug_mode=1 goes to PAUSE next cycle. The current cycle still executes as RUN.
- PAUSE: all enables 0, flush=0, bubble=0.
  - i_step=1 goes to STEP.
  - i_debug_mode=0 goes to RUN.
  - If both are asserted, step wins.
- STEP: one active cycle with the RUN rules above. Next state is PAUSE, or DRAIN if a halt is accepted. i_step asserted during STEP is ignored (no queuing).
- DRAIN: pc_we=0, ifid_we=0, pipe_en=1, bubble=1. The counter decrements each cycle; when it reaches 0 the next state is HALTED. DRAIN ignores i_debug_mode, i_step, i_hazard and i_branch_taken.
- HALTED: all enables 0, o_halted=1. Exit only by reset.
- Stall counter: +1 on every cycle with a hazard-caused bubble in RUN/STEP. It saturates at all-ones. DRAIN bubbles are not counted.

Optional Feature:
STALL_CNT_EN
- Defined: counter logic as above.
- Undefined: no counter flops; o_stall_count is tied to 0. Port is present in both builds.

Decomposition:
- Package pipeline_ctrl_pkg holds: state encoding constants (3 bits: RUN=0, PAUSE=1, STEP=2, DRAIN=3, HALTED=4) and the default DRAIN_CYCLES.
- One natural sub-module: sat_counter (parameterised width, sync active-low clear, enable, saturating). It is instantiated only under STALL_CNT_EN.

Test Plan:
- Reset: hold i_reset=0 for 3 cycles with all inputs 1 -> all enables 0, o_halted=0, count=0. Release -> RUN, pc_we=1 on the first cycle.
- Load-use: i_hazard=1 for 1 cycle -> that cycle pc_we=0, ifid_we=0, bubble=1. Next cycle normal. With STALL_CNT_EN, count=1.
- Hazard+branch same cycle -> flush=0, bubble=1. Branch the next cycle -> flush=1, pc_we=1.
- Halt with DRAIN_CYCLES=4 -> flush=1 on the halt cycle, then 4 DRAIN cycles with bubble=1, then o_halted=1 with all enables 0. Toggling i_step in DRAIN/HALTED has no effect.
- Debug: i_debug_mode=1 -> PAUSE, enables 0. Three i_step pulses spaced 5 cycles apart -> exactly 3 cycles with pc_we=1. Deassert debug -> RUN.
- Saturation: NB_STALL_CNT=2 with hazard held 6 cycles -> count reaches 3 and stays at 3.
